// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable 50%-duty clock divider with rising-edge tick and
// boundary-synchronous divisor reload. Define CLKDIV_RESTART_EN for immediate-restart loads.
`default_nettype none

module clk_div_prog #(
  parameter int unsigned          CNT_W        = 32,
  parameter logic [CNT_W-1:0]     DEFAULT_HALF = CNT_W'(5_000_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic [CNT_W-1:0] div_cur
);

  localparam logic [CNT_W-1:0] c_ZERO = '0;
  localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [0:0]       c_IDLE = 1'b0;
  localparam logic [0:0]       c_PEND = 1'b1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_shadow;
  logic [0:0]       r_state;
  logic             r_clk_out;
  logic             r_tick;

  logic [CNT_W-1:0] w_div;
  logic             w_boundary;
  logic             w_restart;

  assign w_div      = (div_in == c_ZERO) ? c_ONE : div_in;
  assign w_boundary = en && (r_cnt == (r_half - c_ONE));

`ifdef CLKDIV_RESTART_EN
  assign w_restart = load;
`else
  assign w_restart = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= c_ZERO;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_restart) begin
      r_cnt     <= c_ZERO;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (en) begin
      if (w_boundary) begin
        r_cnt     <= c_ZERO;
        r_clk_out <= ~r_clk_out;
        r_tick    <= ~r_clk_out;
      end else begin
        r_cnt     <= r_cnt + c_ONE;
        r_tick    <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  // A load landing on a boundary goes straight into half_reg so the new phase already uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half   <= DEFAULT_HALF;
      r_shadow <= DEFAULT_HALF;
      r_state  <= c_IDLE;
    end else if (w_restart) begin
      r_half   <= w_div;
      r_shadow <= w_div;
      r_state  <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (load && w_boundary) begin
            r_half <= w_div;
          end else if (load) begin
            r_shadow <= w_div;
            r_state  <= c_PEND;
          end
        end
        c_PEND: begin
          if (load && w_boundary) begin
            r_half  <= w_div;
            r_state <= c_IDLE;
          end else if (load) begin
            r_shadow <= w_div;
          end else if (w_boundary) begin
            r_half  <= r_shadow;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;
  assign pending = (r_state == c_PEND);
  assign div_cur = r_half;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (default deferred-load build) against a phase-countdown model.
`default_nettype none

module tb_clk_div_prog;

  localparam int unsigned  W  = 8;
  localparam int           DH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         clk_out, tick, pending;
  logic [W-1:0] div_cur;

  int vecs = 0;
  int errs = 0;

  // Model: cycles left in the current phase, level, half in force, optional queued half.
  int m_left, m_half, m_q;
  bit m_lvl, m_tick, m_qv;

  clk_div_prog #(.CNT_W(W), .DEFAULT_HALF(W'(DH))) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_in(div_in),
    .clk_out(clk_out), .tick(tick), .pending(pending), .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = DH; m_half = DH; m_q = DH;
    m_lvl = 0; m_tick = 0; m_qv = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clk_out"}, 32'(clk_out), 32'(m_lvl));
    chk({tag, ".tick"},    32'(tick),    32'(m_tick));
    chk({tag, ".pending"}, 32'(pending), 32'(m_qv));
    chk({tag, ".div_cur"}, 32'(div_cur), 32'(m_half));
  endtask

  task automatic step(input bit e, input bit ld, input int d, input string tag);
    int  dv;
    bit  bnd;
    en = e; load = ld; div_in = W'(d);
    @(posedge clk);
    dv  = (d == 0) ? 1 : d;
    bnd = 0;
    if (e) begin
      m_left--;
      bnd = (m_left == 0);
    end
    m_tick = bnd && !m_lvl;
    if (bnd) begin
      m_lvl = !m_lvl;
      if (ld)        m_half = dv;
      else if (m_qv) m_half = m_q;
      m_qv   = 0;
      m_left = m_half;
    end else if (ld) begin
      m_q  = dv;
      m_qv = 1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int guard;
    model_reset();
    #12;
    chk("rst.clk_out", 32'(clk_out), 32'd0);
    chk("rst.pending", 32'(pending), 32'd0);
    chk("rst.div_cur", 32'(div_cur), 32'(DH));
    rst = 1'b0;

    // Default period: rises at edges 4,12,20; falls at 8,16.
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0, "default");
      if (i == 4 || i == 12 || i == 20) begin
        chk("default.rise", 32'(clk_out), 32'd1);
        chk("default.tick", 32'(tick), 32'd1);
      end
      if (i == 8 || i == 16) chk("default.fall", 32'(clk_out), 32'd0);
    end

    // Deferred load mid-phase: old phase completes, then 2-cycle phases.
    step(1, 0, 0, "defer");
    step(1, 1, 2, "defer.load");
    chk("defer.pending", 32'(pending), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, "defer.run");

    // Zero divisor coerced to 1.
    step(1, 1, 0, "zero.load");
    for (int i = 0; i < 8; i++) step(1, 0, 0, "zero.run");
    chk("zero.div_cur", 32'(div_cur), 32'd1);

    // Back to 5, then load exactly on a boundary edge.
    step(1, 1, 5, "five.load");
    guard = 0;
    while (m_left != 1 && guard < 100) begin
      step(1, 0, 0, "bnd.wait");
      guard++;
    end
    chk("bnd.reached", 32'(guard < 100), 32'd1);
    step(1, 1, 3, "bnd.load");
    chk("bnd.pending", 32'(pending), 32'd0);
    chk("bnd.div_cur", 32'(div_cur), 32'd3);

    // Enable freeze mid-phase, with a load captured while frozen.
    step(1, 0, 0, "freeze.pre");
    for (int i = 0; i < 5; i++) step(0, (i == 2), 6, "freeze");
    chk("freeze.tick", 32'(tick), 32'd0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, "freeze.resume");

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 5)), "rand");

    // Asynchronous reset between edges with a load pending.
    step(0, 1, 2, "areset.load");
    chk("areset.pending_before", 32'(pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("areset.clk_out", 32'(clk_out), 32'd0);
    chk("areset.pending", 32'(pending), 32'd0);
    chk("areset.div_cur", 32'(div_cur), 32'(DH));
    chk("areset.tick",    32'(tick),    32'd0);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1, 0, 0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
